// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter made of JK flip-flop stages, one per count bit.
// The J/K drive for every stage is generated here; each stage then applies the
// JK rule q+ = (j & ~q) | (~k & q). Counting uses toggle mode (j = k), while
// load and wrap use set/reset mode (j = target, k = ~target).
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset_not,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_wrapped,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_not,
    output logic             terminal_count,
    output logic             carry_out,
    output logic             wrapped,
    output logic             load_error
);

    // MODULUS can equal 2**WIDTH, so the load bound needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] toggle;
    logic             load_ok;
    logic             wrap_step;

    assign count     = q;
    assign count_not = ~q;

    assign terminal_count = (up & (q == MAX_COUNT)) | (~up & (q == '0));
    assign carry_out      = terminal_count & enable & ~load;
    assign load_ok        = ({1'b0, load_value} < MOD_EXT);
    assign wrap_step      = ~load & enable & terminal_count;

    // Ripple-style toggle enables: a bit flips when all lower bits are 1 (up)
    // or all lower bits are 0 (down), giving a plain binary step.
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & (up ? q[i-1] : ~q[i-1]);
        end
    end

    // J/K drive selection: accepted load > wrap > count step > hold.
    always_comb begin
        j = '0;
        k = '0;
        if (load) begin
            if (load_ok) begin
                j = load_value;
                k = ~load_value;
            end
        end else if (enable) begin
            if (terminal_count) begin
                j = up ? '0 : MAX_COUNT;
                k = up ? '1 : ~MAX_COUNT;
            end else begin
                j = toggle;
                k = toggle;
            end
        end
    end

    // JK storage stages.
    always_ff @(posedge clock or negedge reset_not) begin
        if (!reset_not) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

    // Sticky wrap flag (a wrap beats a same-edge clear) and reject pulse.
    always_ff @(posedge clock or negedge reset_not) begin
        if (!reset_not) begin
            wrapped    <= 1'b0;
            load_error <= 1'b0;
        end else begin
            if (wrap_step) begin
                wrapped <= 1'b1;
            end else if (clear_wrapped) begin
                wrapped <= 1'b0;
            end
            load_error <= load & ~load_ok;
        end
    end

endmodule
